mem_mgr_axi_burst: RTL

- Parametrised successor to the tile's single-beat AXI memory manager. Converts a ready/valid memory request stream into AXI4 INCR bursts (1..2^S_AXI_LEN_SZ beats) with per-beat write data and multiple outstanding reads/writes.
- Returns read data per beat and write completions, tagged with ID and response.
- Sits between the DRAM tile's cache/queue logic and the AXI DDR controller port.

---
 rtl/mem_mgr_axi_burst_if.sv | 83 ++++++++
 rtl/mem_mgr_axi_burst.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mgr_axi_burst_if.sv
// AXI4 master-side bundle used by mem_mgr_axi_burst to reach the DDR controller.
// Channels: AW, W, B, AR, R.
// The master modport is the memory manager's view. The slave modport is the
// controller's view.
interface mem_mgr_axi_burst_if #(
  parameter int DATA_SZ = 512,
  parameter int ID_SZ   = 11,
  parameter int ADR_SZ  = 29,
  parameter int LEN_SZ  = 8
);
  // Write address channel
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [ID_SZ-1:0]    s_axi_awid;
  logic [ADR_SZ-1:0]   s_axi_awaddr;
  logic [LEN_SZ-1:0]   s_axi_awlen;
  logic [2:0]          s_axi_awsize;
  logic [1:0]          s_axi_awburst;
  logic                s_axi_awlock;
  logic [3:0]          s_axi_awcache;
  logic [2:0]          s_axi_awprot;
  logic [3:0]          s_axi_awqos;
  // Write data channel
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [DATA_SZ-1:0]  s_axi_wdata;
  logic [DATA_SZ/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  // Write response channel
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ID_SZ-1:0]    s_axi_bid;
  logic [1:0]          s_axi_bresp;
  // Read address channel
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [ID_SZ-1:0]    s_axi_arid;
  logic [ADR_SZ-1:0]   s_axi_araddr;
  logic [LEN_SZ-1:0]   s_axi_arlen;
  logic [2:0]          s_axi_arsize;
  logic [1:0]          s_axi_arburst;
  logic                s_axi_arlock;
  logic [3:0]          s_axi_arcache;
  logic [2:0]          s_axi_arprot;
  logic [3:0]          s_axi_arqos;
  // Read data channel
  logic                s_axi_rvalid;
  logic                s_axi_rready;
  logic [DATA_SZ-1:0]  s_axi_rdata;
  logic [ID_SZ-1:0]    s_axi_rid;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rlast;

  modport master (
    output s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
           s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
    input  s_axi_awready,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    input  s_axi_wready,
    input  s_axi_bvalid, s_axi_bid, s_axi_bresp,
    output s_axi_bready,
    output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
           s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awvalid, s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
           s_axi_awburst, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
    output s_axi_awready,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
    output s_axi_wready,
    output s_axi_bvalid, s_axi_bid, s_axi_bresp,
    input  s_axi_bready,
    input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize,
           s_axi_arburst, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast,
    input  s_axi_rready
  );
endinterface

// File: rtl/mem_mgr_axi_burst.sv
// Memory manager that turns a ready/valid request stream into AXI4 INCR
// bursts. It supports multiple outstanding reads and writes per direction.
// Ports:
//   clk_ctrl, clk_ctrl_rst : clock and synchronous active-high reset
//   req_*                  : burst request (rw, byte address, id, beats-1)
//   wr_valid/ready/data/strb : per-beat write data into the W channel
//   rd_*                   : read beats forwarded from the R channel
//   wr_rsp_*               : write completions forwarded from the B channel
//   axi                    : AXI4 master port to the DDR controller
module mem_mgr_axi_burst #(
  parameter int MEM_BUS_SZ      = 512,
  parameter int S_AXI_ID_SZ     = 11,
  parameter int S_AXI_ADR_SZ    = 29,
  parameter int S_AXI_LEN_SZ    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_ctrl,
  input  logic                    clk_ctrl_rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [31:0]             req_addr,
  input  logic [S_AXI_ID_SZ-1:0]  req_id,
  input  logic [S_AXI_LEN_SZ-1:0] req_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [MEM_BUS_SZ-1:0]   wr_data,
  input  logic [MEM_BUS_SZ/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [MEM_BUS_SZ-1:0]   rd_data,
  output logic [S_AXI_ID_SZ-1:0]  rd_id,
  output logic [1:0]              rd_resp,
  output logic                    rd_last,
  output logic                    wr_rsp_valid,
  input  logic                    wr_rsp_ready,
  output logic [S_AXI_ID_SZ-1:0]  wr_rsp_id,
  output logic [1:0]              wr_rsp_resp,
  mem_mgr_axi_burst_if.master     axi
);
  localparam int SIZE_LOG = $clog2(MEM_BUS_SZ / 8);
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [S_AXI_ADR_SZ-1:0] ADDR_MASK =
    ~S_AXI_ADR_SZ'((64'd1 << SIZE_LOG) - 64'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE_AW = 2'd1,
    WRITE_W  = 2'd2,
    READ_AR  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [S_AXI_LEN_SZ-1:0] beat_cnt, beat_nxt;
  logic [S_AXI_ID_SZ-1:0]  aw_id, aw_id_nxt, ar_id, ar_id_nxt;
  logic [S_AXI_LEN_SZ-1:0] aw_len, aw_len_nxt, ar_len, ar_len_nxt;
  logic [S_AXI_ADR_SZ-1:0] aw_addr, aw_addr_nxt, ar_addr, ar_addr_nxt;
  logic [CNT_W-1:0]        rd_out, rd_out_nxt, wr_out, wr_out_nxt;
  logic [S_AXI_ADR_SZ-1:0] addr_aligned;
  logic active, dir_free, req_hs, aw_valid, ar_valid, w_valid, w_last, w_hs;
  logic aw_hs, ar_hs, r_done, b_done;

  // Outputs are held low while reset is asserted, not only after it takes effect.
  assign active       = ~clk_ctrl_rst;
  assign addr_aligned = req_addr[S_AXI_ADR_SZ-1:0] & ADDR_MASK;
  // Acceptance depends on the requested direction only, never on req_valid.
  assign dir_free     = req_rw ? (wr_out < MAX_CNT) : (rd_out < MAX_CNT);

  // Next-state logic and the channel-control outputs of the burst FSM.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_cnt;
    aw_id_nxt   = aw_id;
    aw_len_nxt  = aw_len;
    aw_addr_nxt = aw_addr;
    ar_id_nxt   = ar_id;
    ar_len_nxt  = ar_len;
    ar_addr_nxt = ar_addr;
    req_ready   = 1'b0;
    req_hs      = 1'b0;
    aw_valid    = 1'b0;
    ar_valid    = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_hs        = 1'b0;
    wr_ready    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = active & dir_free;
        req_hs    = req_valid & req_ready;
        if (req_hs) begin
          if (req_rw) begin
            state_nxt   = WRITE_AW;
            aw_id_nxt   = req_id;
            aw_len_nxt  = req_len;
            aw_addr_nxt = addr_aligned;
            beat_nxt    = req_len;
          end else begin
            state_nxt   = READ_AR;
            ar_id_nxt   = req_id;
            ar_len_nxt  = req_len;
            ar_addr_nxt = addr_aligned;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE_AW: begin
        aw_valid = active;
        if (axi.s_axi_awready) begin
          state_nxt = WRITE_W;
        end else begin
          state_nxt = WRITE_AW;
        end
      end
      WRITE_W: begin
        w_valid  = active & wr_valid;
        wr_ready = active & axi.s_axi_wready;
        w_last   = active & (beat_cnt == {S_AXI_LEN_SZ{1'b0}});
        w_hs     = w_valid & axi.s_axi_wready;
        if (w_hs) begin
          if (w_last) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = WRITE_W;
            beat_nxt  = beat_cnt - S_AXI_LEN_SZ'(1);
          end
        end else begin
          state_nxt = WRITE_W;
        end
      end
      READ_AR: begin
        ar_valid = active;
        if (axi.s_axi_arready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = READ_AR;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign aw_hs  = aw_valid & axi.s_axi_awready;
  assign ar_hs  = ar_valid & axi.s_axi_arready;
  // The nonzero guards prevent a stray response from wrapping a counter.
  assign r_done = axi.s_axi_rvalid & rd_ready & axi.s_axi_rlast & (rd_out != {CNT_W{1'b0}});
  assign b_done = axi.s_axi_bvalid & wr_rsp_ready & (wr_out != {CNT_W{1'b0}});

  // Outstanding-transaction counters. A simultaneous issue and retire cancel out.
  always_comb begin
    rd_out_nxt = rd_out;
    wr_out_nxt = wr_out;
    case ({ar_hs, r_done})
      2'b10:   rd_out_nxt = rd_out + CNT_W'(1);
      2'b01:   rd_out_nxt = rd_out - CNT_W'(1);
      default: rd_out_nxt = rd_out;
    endcase
    case ({aw_hs, b_done})
      2'b10:   wr_out_nxt = wr_out + CNT_W'(1);
      2'b01:   wr_out_nxt = wr_out - CNT_W'(1);
      default: wr_out_nxt = wr_out;
    endcase
  end

  // State, captured burst fields, and counter registers.
  always_ff @(posedge clk_ctrl) begin
    if (clk_ctrl_rst) begin
      state    <= IDLE;
      beat_cnt <= {S_AXI_LEN_SZ{1'b0}};
      aw_id    <= {S_AXI_ID_SZ{1'b0}};
      aw_len   <= {S_AXI_LEN_SZ{1'b0}};
      aw_addr  <= {S_AXI_ADR_SZ{1'b0}};
      ar_id    <= {S_AXI_ID_SZ{1'b0}};
      ar_len   <= {S_AXI_LEN_SZ{1'b0}};
      ar_addr  <= {S_AXI_ADR_SZ{1'b0}};
      rd_out   <= {CNT_W{1'b0}};
      wr_out   <= {CNT_W{1'b0}};
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      aw_id    <= aw_id_nxt;
      aw_len   <= aw_len_nxt;
      aw_addr  <= aw_addr_nxt;
      ar_id    <= ar_id_nxt;
      ar_len   <= ar_len_nxt;
      ar_addr  <= ar_addr_nxt;
      rd_out   <= rd_out_nxt;
      wr_out   <= wr_out_nxt;
    end
  end

  assign axi.s_axi_awvalid = aw_valid;
  assign axi.s_axi_awid    = aw_id;
  assign axi.s_axi_awaddr  = aw_addr;
  assign axi.s_axi_awlen   = aw_len;
  assign axi.s_axi_awsize  = 3'(SIZE_LOG);
  assign axi.s_axi_awburst = 2'b01;
  assign axi.s_axi_awlock  = 1'b0;
  assign axi.s_axi_awcache = 4'b0000;
  assign axi.s_axi_awprot  = 3'b000;
  assign axi.s_axi_awqos   = 4'b0000;
  assign axi.s_axi_wvalid  = w_valid;
  assign axi.s_axi_wdata   = wr_data;
  assign axi.s_axi_wstrb   = wr_strb;
  assign axi.s_axi_wlast   = w_last;
  assign axi.s_axi_arvalid = ar_valid;
  assign axi.s_axi_arid    = ar_id;
  assign axi.s_axi_araddr  = ar_addr;
  assign axi.s_axi_arlen   = ar_len;
  assign axi.s_axi_arsize  = 3'(SIZE_LOG);
  assign axi.s_axi_arburst = 2'b01;
  assign axi.s_axi_arlock  = 1'b0;
  assign axi.s_axi_arcache = 4'b0000;
  assign axi.s_axi_arprot  = 3'b000;
  assign axi.s_axi_arqos   = 4'b0000;

  // Response channels are forwarded as-is, in the order the slave returns them.
  assign rd_valid          = axi.s_axi_rvalid;
  assign rd_data           = axi.s_axi_rdata;
  assign rd_id             = axi.s_axi_rid;
  assign rd_resp           = axi.s_axi_rresp;
  assign rd_last           = axi.s_axi_rlast;
  assign axi.s_axi_rready  = rd_ready;
  assign wr_rsp_valid      = axi.s_axi_bvalid;
  assign wr_rsp_id         = axi.s_axi_bid;
  assign wr_rsp_resp       = axi.s_axi_bresp;
  assign axi.s_axi_bready  = wr_rsp_ready;
endmodule
